// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: shares one single-ported synchronous SRAM between the fetch (I) and
// data (D) request channels. One request per cycle, tagged in-order read return.
// Optional feature: define MEM_RR_ARB_EN for round-robin arbitration; otherwise D has
// fixed priority over I.
module mem_arb_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 16384,
    parameter int unsigned SRAM_LAT = 1,
    localparam int unsigned BE_W    = DATA_W / 8,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned OFF_W   = $clog2(BE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [BE_W-1:0]   d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [AW-1:0]     sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_d_write;
    logic              w_rd_push;
    logic [AW-1:0]     w_word_a;
    logic              w_exit_v;
    logic              w_exit_d;
    logic              w_unused_addr;

    // Tag pipeline: valid bit and channel (1 = D) per in-flight read.
    logic [SRAM_LAT-1:0] r_tag_v;
    logic [SRAM_LAT-1:0] r_tag_d;
    logic                r_i_rsp_valid;
    logic                r_d_rsp_valid;
    logic [DATA_W-1:0]   r_i_rsp_data;
    logic [DATA_W-1:0]   r_d_rsp_data;

`ifdef MEM_RR_ARB_EN
    // 1 = D was granted last; reset as "I last" so D wins the first conflict.
    logic r_last_d;

    assign w_grant_d = rst && d_req_valid && (!i_req_valid || !r_last_d);

    // Last-granted pointer moves only when a request is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant_i || w_grant_d) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = rst && d_req_valid;
`endif

    // Both readys are forced low while reset is asserted.
    assign w_grant_i   = rst && i_req_valid && !w_grant_d;
    assign i_req_ready = w_grant_i;
    assign d_req_ready = w_grant_d;

    assign w_d_write = w_grant_d && (d_req_we != '0);
    assign w_rd_push = w_grant_i || (w_grant_d && (d_req_we == '0));
    assign w_word_a  = w_grant_d ? d_req_addr[AW+OFF_W-1:OFF_W] : i_req_addr[AW+OFF_W-1:OFF_W];

    // Byte offset and bits above the word range are deliberately ignored.
    assign w_unused_addr = ^{i_req_addr, d_req_addr};

    // SRAM pins: idle values by default, request values on an accepted cycle.
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (w_grant_i || w_grant_d) begin
            sram_ceb = 1'b0;
            sram_a   = w_word_a;
            if (w_d_write) begin
                sram_web = 1'b0;
                sram_di  = d_req_wdata;
                for (int unsigned k = 0; k < BE_W; k++) begin
                    sram_bweb[k*8 +: 8] = {8{~d_req_we[k]}};
                end
            end
        end
    end

    assign w_exit_v = r_tag_v[SRAM_LAT-1];
    assign w_exit_d = r_tag_d[SRAM_LAT-1];

    // Shift read tags along so each exits when its SRAM data is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            r_tag_d <= '0;
        end else begin
            r_tag_v[0] <= w_rd_push;
            r_tag_d[0] <= w_grant_d;
            for (int unsigned k = 1; k < SRAM_LAT; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag_d[k] <= r_tag_d[k-1];
            end
        end
    end

    // Capture read data into the owning channel; data holds between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_i_rsp_data  <= '0;
            r_d_rsp_data  <= '0;
        end else begin
            r_i_rsp_valid <= w_exit_v && !w_exit_d;
            r_d_rsp_valid <= w_exit_v && w_exit_d;
            if (w_exit_v && !w_exit_d) begin
                r_i_rsp_data <= sram_do;
            end
            if (w_exit_v && w_exit_d) begin
                r_d_rsp_data <= sram_do;
            end
        end
    end

    assign i_rsp_valid = r_i_rsp_valid;
    assign d_rsp_valid = r_d_rsp_valid;
    assign i_rsp_data  = r_i_rsp_data;
    assign d_rsp_data  = r_d_rsp_data;

endmodule

// File: doc/mem_arb_ctrl.md
# mem_arb_ctrl

Two-channel memory controller sharing one single-ported synchronous SRAM macro between the CPU's instruction-fetch (I) and data (D) paths. It is the parametrised successor to a hard-wired fetch/data SRAM hookup. It adds valid/ready request handshakes, per-cycle arbitration, configurable data width, depth and SRAM read latency, and an in-order tagged read-return pipeline. It sits between the CPU pipeline and an active-low SRAM wrapper (CEB/WEB/BWEB style).

## Interface
- DATA_W, 32, data width in bits; multiple of 8; BE_W = DATA_W/8
- ADDR_W, 16, CPU byte-address width
- DEPTH, 16384, SRAM words; AW = clog2(DEPTH)
- SRAM_LAT, 1, SRAM read latency in cycles, 1..4
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch accepted this cycle
- i_req_addr  in  ADDR_W  fetch byte address
- i_rsp_valid  out  1  fetch data valid, one-cycle pulse
- i_rsp_data  out  DATA_W  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data accepted this cycle
- d_req_addr  in  ADDR_W  data byte address
- d_req_we  in  BE_W  byte write enables; all-zero = read
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  load data valid, one-cycle pulse
- d_rsp_data  out  DATA_W  load data
- sram_ceb  out  1  chip enable, active-low
- sram_web  out  1  write enable, active-low
- sram_bweb  out  DATA_W  bit write enable, active-low
- sram_a  out  AW  word address
- sram_di  out  DATA_W  write data
- sram_do  in  DATA_W  read data

## Operation
- The block accepts at most one request per cycle. A request is accepted when valid && ready. Ready is combinational from the valids and the arbitration state.
- Default arbitration is fixed priority: D over I. `i_req_ready = i_req_valid && !d_req_valid`. `d_req_ready = d_req_valid`.
- Word address = `addr[AW+log2(BE_W)-1 : log2(BE_W)]`. Low byte-offset bits and address bits above that range are ignored.
- Accepted cycle drives: `sram_ceb=0`, `sram_a` = word address. For a D write (`d_req_we != 0`): `sram_web=0`, `sram_di=d_req_wdata`, `sram_bweb` byte k = `{8{~d_req_we[k]}}`. Reads use `sram_web=1` and all-ones `sram_bweb`.
- Idle cycle drives: `sram_ceb=1`, `sram_web=1`, `sram_bweb` all ones, `sram_a=0`, `sram_di=0`.
- Writes produce no response.
- Each accepted read pushes tag {valid, chan} into a SRAM_LAT-deep shift register. When a valid tag exits, `sram_do` is registered into that channel's rsp_data and its rsp_valid pulses for one cycle.
- No response backpressure. rsp_data holds its last value until the next response on the same channel.
- Responses return in issue order. Up to SRAM_LAT reads may be in flight.

## Timing
- Read accepted in cycle T → `sram_do` valid in T+SRAM_LAT → rsp_valid/data in T+SRAM_LAT+1. SRAM_LAT=1 gives a 2-cycle load-to-use.
- Full throughput: one read or write per cycle, back-to-back, across any mix of channels.
- A read issued at T+1 to the address written at T returns the new data; ordering is guaranteed by the SRAM.
- Reset (rst=0) values: all rsp_valid=0, all rsp_data=0, tag pipeline cleared, RR pointer = "I last granted". SRAM outputs take idle values (they are combinational from valid=0 readiness, and both ready=0 during reset).
- Reset mid-operation: in-flight reads are discarded and no response follows deassertion. The first request is accepted in the first cycle with rst=1.

## Configuration
- `MEM_RR_ARB_EN` defined: round-robin arbitration. On an I/D conflict, the channel not granted last wins. The last-granted pointer updates only on an accepted request. An uncontended request is always granted immediately.
- Undefined: fixed D-over-I priority. I can starve under continuous D traffic.

## Test plan
- Reset: hold rst=0 with both valids high → both readys 0, both rsp_valid 0, sram_ceb=1. Release → D granted first.
- Fetch: write 0xDEADBEEF at byte 0x40 via D (we=4'hF); then I read at 0x40 → i_rsp_valid exactly 2 cycles later (SRAM_LAT=1) with 0xDEADBEEF.
- Byte write: write 0x11223344 at 0x80, then we=4'b0100 with data 0x00AA0000 → D read returns 0x11AA3344. sram_bweb = 0xFF00FFFF during the byte write.
- Conflict: both valid for 4 cycles → fixed mode grants D,D,D,D. With MEM_RR_ARB_EN → D,I,D,I (pointer reset as I-last).
- Pipelining, SRAM_LAT=3: reads I@0x0, D@0x4, I@0x8 on consecutive cycles → responses on consecutive cycles T+4..T+6, in order, to the correct channels.
- Reset mid-flight: issue a read, assert rst the next cycle, release → no rsp_valid ever observed for that read.
